serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor. It computes A - B - Bin LSB-first through a single full-subtractor cell and a registered borrow, one bit per clock. It is the inverse-operation counterpart of the team's combinational full-adder cell and serves as the subtract path in the lab ALU datapath. The block uses a start/busy/done handshake toward the controlling sequencer.

---
 rtl/alu_pkg.sv | 13 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU serial arithmetic blocks.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_t;

    // Default operand width, shared with the adder-side serial block.
    localparam int ALU_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - Bin, LSB first, one bit per clock,
// with a start/busy/done handshake toward the controlling sequencer.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_full;

    full_subtractor u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // The result register holds only the WIDTH-1 bits already produced; the
    // current cell output completes the word on the final step.
    assign res_full = {cell_d, res_q};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_bo;
                res_d = res_full[WIDTH-1:1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    diff_d  = res_full;
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random operations at WIDTH=8 and 16,
// compared against plain integer subtraction, plus the standalone cell table.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8, bin8, busy8, done8, bout8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bout16;
    logic [15:0] a16, b16, diff16;
    logic        fx, fy, fbi, fd, fbo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_diff [2];
    logic        last_bout [2];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
    );

    full_subtractor u_fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy8 : busy16;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done8 : done16;
    endfunction

    function automatic logic [63:0] get_diff(input int sel);
        return (sel == 0) ? 64'(diff8) : 64'(diff16);
    endfunction

    function automatic logic get_bout(input int sel);
        return (sel == 0) ? bout8 : bout16;
    endfunction

    task automatic drive(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input logic st);
        if (sel == 0) begin
            a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; start8 = st;
        end else begin
            a16 = av[15:0]; b16 = bv[15:0]; bin16 = bi; start16 = st;
        end
    endtask

    // Starts one operation at a negedge and returns at the negedge after the
    // done pulse, with the unit back in IDLE.
    task automatic do_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input string tag);
        int          w;
        logic [63:0] mask;
        longint      r;
        logic [63:0] exp_diff;
        logic        exp_bout;
        int          c;
        int          busy_n;
        bit          got;

        w        = (sel == 0) ? 8 : 16;
        mask     = (64'd1 << w) - 64'd1;
        r        = longint'(64'(av) & mask) - longint'(64'(bv) & mask) - longint'(bi);
        exp_diff = 64'(r) & mask;
        exp_bout = (r < 0);

        drive(sel, av, bv, bi, 1'b1);
        @(negedge clk);
        drive(sel, $urandom, $urandom, 1'($urandom_range(1)), 1'b0);

        c = 0;
        busy_n = 0;
        got = 0;
        while (!got && c < w + 4) begin
            if (get_busy(sel)) busy_n++;
            if (get_done(sel)) begin
                got = 1;
            end else begin
                check({tag, " hold_diff"}, get_diff(sel), last_diff[sel]);
                @(negedge clk);
                c++;
            end
        end

        check({tag, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(c), 64'(w));
            check({tag, " busy_cycles"}, 64'(busy_n), 64'(w));
            check({tag, " diff"}, get_diff(sel), exp_diff);
            check({tag, " bout"}, 64'(get_bout(sel)), 64'(exp_bout));
            last_diff[sel] = exp_diff;
            last_bout[sel] = exp_bout;
            @(negedge clk);
            check({tag, " done_width"}, 64'(get_done(sel)), 64'd0);
            check({tag, " diff_after"}, get_diff(sel), exp_diff);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int  nd;
        int  w;
        logic [2:0] v;
        int  r;

        rst_n = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 1'b0, 1'b0);
        last_diff[0] = '0; last_diff[1] = '0;
        last_bout[0] = 1'b0; last_bout[1] = 1'b0;

        // Standalone cell truth table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            fx = v[2]; fy = v[1]; fbi = v[0];
            #1;
            r = int'(fx) - int'(fy) - int'(fbi);
            check($sformatf("cell_d %0d", i), 64'(fd), 64'(r & 1));
            check($sformatf("cell_bo %0d", i), 64'(fbo), 64'(r < 0));
        end

        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy8), 64'd0);
        check("rst done", 64'(done8), 64'd0);
        check("rst diff", 64'(diff8), 64'd0);
        check("rst bout", 64'(bout8), 64'd0);
        check("rst busy16", 64'(busy16), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 32'h5A, 32'h3C, 1'b0, "d5A_3C");
        do_op(0, 32'h00, 32'h01, 1'b0, "d00_01");
        do_op(0, 32'h10, 32'h0F, 1'b1, "d10_0F");
        do_op(0, 32'h00, 32'hFF, 1'b1, "d00_FF");
        do_op(0, 32'hFF, 32'h00, 1'b0, "dFF_00");

        // start held high, operands changed mid-SHIFT.
        w = 8;
        drive(0, 32'h5A, 32'h3C, 1'b0, 1'b1);
        @(negedge clk);
        for (int idx = 0; idx <= 2 * w + 2; idx++) begin
            if (idx == 3) drive(0, 32'h77, 32'h11, 1'b0, 1'b1);
            check($sformatf("held done@%0d", idx), 64'(done8),
                  64'((idx == w) || (idx == 2 * w + 2)));
            if (idx == w) begin
                check("held diff1", 64'(diff8), 64'h1E);
                check("held bout1", 64'(bout8), 64'd0);
            end
            if (idx == 2 * w + 2) begin
                check("held diff2", 64'(diff8), 64'h66);
                check("held bout2", 64'(bout8), 64'd0);
            end
            if (idx < 2 * w + 2) @(negedge clk);
        end
        start8 = 1'b0;
        @(negedge clk);
        last_diff[0] = 64'h66;
        last_bout[0] = 1'b0;

        // Asynchronous reset in the middle of an operation.
        do_op(0, 32'h5A, 32'h3C, 1'b0, "pre_rst");
        drive(0, 32'hC3, 32'h12, 1'b1, 1'b1);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst busy", 64'(busy8), 64'd0);
        check("mid_rst done", 64'(done8), 64'd0);
        check("mid_rst diff", 64'(diff8), 64'd0);
        check("mid_rst bout", 64'(bout8), 64'd0);
        last_diff[0] = '0; last_diff[1] = '0;
        last_bout[0] = 1'b0; last_bout[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < w + 4; i++) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        check("post_rst no_activity", 64'(nd), 64'd0);
        do_op(0, 32'hA5, 32'h5A, 1'b1, "post_rst");

        do_op(1, 32'h0000, 32'h0001, 1'b0, "w16 00_01");
        do_op(1, 32'hFFFF, 32'hFFFF, 1'b1, "w16 FF_FF");

        for (int i = 0; i < 1000; i++)
            do_op(0, $urandom, $urandom, 1'($urandom_range(1)), "rnd8");
        for (int i = 0; i < 1000; i++)
            do_op(1, $urandom, $urandom, 1'($urandom_range(1)), "rnd16");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
